vector_regfile_mp: RTL and testbench

//  Parametrised vector register file: NUM_REGS regs of LANES x LANE_W bits, two read ports, one write port.

---
 rtl/vrf_pkg.sv | 18 +
 rtl/vrf_scoreboard.sv | 41 ++++
 rtl/vector_regfile_mp.sv | 136 +++++++++++++
 tb/tb_vector_regfile_mp.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared types and helpers for the vector register file: clear-sweep state
// encoding, default lane geometry and lane slicing.
package vrf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } vrf_state_e;

    localparam int VRF_LANES  = 8;
    localparam int VRF_LANE_W = 32;

    // Bit offset of a lane inside a packed vector register.
    function automatic int lane_lo(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// One pending bit per vector register: set on issue, cleared on writeback,
// flushed wholesale by the clear sweep. Issue wins over writeback to the same reg.
module vrf_scoreboard
    import vrf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] look_a1,
    input  logic [ADDR_W-1:0] look_a2,
    output logic              pend1,
    output logic              pend2
);

    logic [NUM_REGS-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr) pend_d[clr_addr] = 1'b0;
        if (set) pend_d[set_addr] = 1'b1;
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
        if (flush) pend_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign pend1 = pend_q[look_a1];
    assign pend2 = pend_q[look_a2];

endmodule

// File: rtl/vector_regfile_mp.sv
// Vector register file with two combinational read ports, one lane-masked
// write port with same-cycle bypass, a clear sweep FSM and a pending scoreboard.
module vector_regfile_mp
    import vrf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int LANES    = VRF_LANES,
    parameter int LANE_W   = VRF_LANE_W,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    localparam int VW      = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [VW-1:0]     rd1,
    output logic [VW-1:0]     rd2,
    output logic              rd1_pend,
    output logic              rd2_pend,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [LANES-1:0]  wmask,
    input  logic [VW-1:0]     wd,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr
);

    vrf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_busy_q, clr_busy_d;

    logic [VW-1:0]     mem_q [NUM_REGS];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [VW-1:0]     wr_val;
    logic              sb_p1, sb_p2;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(NUM_REGS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        clr_busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign clr_busy = clr_busy_q;

    // The sweep owns the single write port while busy; normal writes merge lanes.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = clr_busy_q ? ptr_q : wa;
        wr_val = '0;
        if (clr_busy_q) begin
            wr_en = 1'b1;
        end else if (we && !((ZERO_REG != 0) && (wa == '0))) begin
            wr_en = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                wr_val[lane_lo(i, LANE_W) +: LANE_W] = wmask[i]
                    ? wd[lane_lo(i, LANE_W) +: LANE_W]
                    : mem_q[wa][lane_lo(i, LANE_W) +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_val;
    end

    function automatic logic [VW-1:0] read_lanes(input logic [VW-1:0] stored,
                                                 input logic hit);
        logic [VW-1:0] r;
        r = stored;
        for (int i = 0; i < LANES; i++) begin
            if (hit && wmask[i]) r[lane_lo(i, LANE_W) +: LANE_W] = wd[lane_lo(i, LANE_W) +: LANE_W];
        end
        return r;
    endfunction

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!clr_busy_q && !((ZERO_REG != 0) && (ra1 == '0)))
            rd1 = read_lanes(mem_q[ra1], we && (wa == ra1));
        if (!clr_busy_q && !((ZERO_REG != 0) && (ra2 == '0)))
            rd2 = read_lanes(mem_q[ra2], we && (wa == ra2));
    end

    vrf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clr_busy_q | clr_req),
        .set      (sb_set & ~clr_busy_q),
        .set_addr (sb_addr),
        .clr      (we & ~clr_busy_q),
        .clr_addr (wa),
        .look_a1  (ra1),
        .look_a2  (ra2),
        .pend1    (sb_p1),
        .pend2    (sb_p2)
    );

    // A writeback landing this cycle already satisfies the reader.
    assign rd1_pend = ~clr_busy_q & sb_p1 & ~(we && (wa == ra1));
    assign rd2_pend = ~clr_busy_q & sb_p2 & ~(we && (wa == ra2));

endmodule

// File: tb/tb_vector_regfile_mp.sv
// Directed bench for vector_regfile_mp: vector table for write/read/bypass/
// scoreboard behaviour plus hand sequences for the clear sweep and reset.
module tb_vector_regfile_mp;

  localparam logic [31:0] A = 32'hAAAA_AAAA;
  localparam logic [255:0] Z = '0;
  localparam logic [255:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr_req;
  logic         clr_busy;
  logic [4:0]   ra1, ra2;
  logic [255:0] rd1, rd2;
  logic         rd1_pend, rd2_pend;
  logic         we;
  logic [4:0]   wa;
  logic [7:0]   wmask;
  logic [255:0] wd;
  logic         sb_set;
  logic [4:0]   sb_addr;

  int total = 0;
  int passed = 0;

  vector_regfile_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .rd1_pend (rd1_pend),
    .rd2_pend (rd2_pend),
    .we       (we),
    .wa       (wa),
    .wmask    (wmask),
    .wd       (wd),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         we;
    logic [4:0]   wa;
    logic [7:0]   wmask;
    logic [255:0] wd;
    logic         sb_set;
    logic [4:0]   sb_addr;
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic [255:0] exp_rd1;
    logic [255:0] exp_rd2;
    logic         exp_p1;
    logic         exp_p2;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic logic [255:0] mk8(input logic [31:0] l7, l6, l5, l4, l3, l2, l1, l0);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic vec_t mkv(input string nm, input logic w, input logic [4:0] a,
                               input logic [7:0] m, input logic [255:0] d,
                               input logic s, input logic [4:0] sa,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [255:0] e1, input logic [255:0] e2,
                               input logic p1, input logic p2);
    vec_t v;
    v.name = nm; v.we = w; v.wa = a; v.wmask = m; v.wd = d;
    v.sb_set = s; v.sb_addr = sa; v.ra1 = r1; v.ra2 = r2;
    v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_p1 = p1; v.exp_p2 = p2;
    return v;
  endfunction

  // scoreboard check
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wmask = '0; wd = '0;
    sb_set = 1'b0; sb_addr = '0; clr_req = 1'b0;
  endtask

  // Walks a busy period one cycle at a time. Pokes we/sb_set/clr_req at busy
  // cycle 5 (all must be ignored) and optionally pulses rst_n at cycle rst_at,
  // restarting the count from the release cycle.
  task automatic sweep(input int rst_at, output int n, output int bad);
    bit did_rst;
    n = 0; bad = 0; did_rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!clr_busy) break;
      n++;
      if (n == 5) begin
        we = 1'b1; wa = 5'd5; wd = ONES; wmask = 8'hFF;
        sb_set = 1'b1; sb_addr = 5'd5; clr_req = 1'b1;
      end else begin
        we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
      end
      #1;
      if (rd1 !== Z || rd2 !== Z || rd1_pend !== 1'b0 || rd2_pend !== 1'b0) bad++;
      if (n == rst_at && !did_rst) begin
        did_rst = 1'b1;
        rst_n = 1'b0;
        #1;
        if (clr_busy !== 1'b1 || rd1 !== Z) bad++;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        #2;
        continue;
      end
      @(negedge clk); #2;
    end
    idle_inputs();
  endtask

  initial begin
    int n, bad, errs;

    tbl[0]  = mkv("w5_full", 1, 5, 8'hFF, mk8(8,7,6,5,4,3,2,1), 0, 0, 5, 0,
                  mk8(8,7,6,5,4,3,2,1), Z, 0, 0);
    tbl[1]  = mkv("w5_mask0f", 1, 5, 8'h0F, mk8(A,A,A,A,A,A,A,A), 0, 0, 5, 5,
                  mk8(8,7,6,5,A,A,A,A), mk8(8,7,6,5,A,A,A,A), 0, 0);
    tbl[2]  = mkv("r5_stored", 0, 0, 8'h00, Z, 0, 0, 5, 5,
                  mk8(8,7,6,5,A,A,A,A), mk8(8,7,6,5,A,A,A,A), 0, 0);
    tbl[3]  = mkv("w7_full", 1, 7, 8'hFF, mk8(107,106,105,104,103,102,101,100), 0, 0, 7, 5,
                  mk8(107,106,105,104,103,102,101,100), mk8(8,7,6,5,A,A,A,A), 0, 0);
    tbl[4]  = mkv("w7_bypass_l0", 1, 7, 8'h01, {8{32'hDEAD_BEEF}}, 0, 0, 7, 7,
                  mk8(107,106,105,104,103,102,101,32'hDEAD_BEEF),
                  mk8(107,106,105,104,103,102,101,32'hDEAD_BEEF), 0, 0);
    tbl[5]  = mkv("r7_stored", 0, 0, 8'h00, Z, 0, 0, 7, 7,
                  mk8(107,106,105,104,103,102,101,32'hDEAD_BEEF),
                  mk8(107,106,105,104,103,102,101,32'hDEAD_BEEF), 0, 0);
    tbl[6]  = mkv("sb9_set", 0, 0, 8'h00, Z, 1, 9, 9, 9, Z, Z, 0, 0);
    tbl[7]  = mkv("sb9_pend", 0, 0, 8'h00, Z, 0, 0, 9, 7,
                  Z, mk8(107,106,105,104,103,102,101,32'hDEAD_BEEF), 1, 0);
    tbl[8]  = mkv("w9_clears_pend", 1, 9, 8'hFF, mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50),
                  0, 0, 9, 9, mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 0, 0);
    tbl[9]  = mkv("r9_stored", 0, 0, 8'h00, Z, 0, 0, 9, 9,
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 0, 0);
    tbl[10] = mkv("sb_we_same9", 1, 9, 8'h00, ONES, 1, 9, 9, 9,
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 0, 0);
    tbl[11] = mkv("set_wins9", 0, 0, 8'h00, Z, 0, 0, 9, 9,
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 1, 1);
    tbl[12] = mkv("w9_mask0", 1, 9, 8'h00, ONES, 0, 0, 9, 9,
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 0, 0);
    tbl[13] = mkv("r9_not_pend", 0, 0, 8'h00, Z, 0, 0, 9, 9,
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 0, 0);
    tbl[14] = mkv("w0_sb0", 1, 0, 8'hFF, ONES, 1, 0, 0, 0, Z, Z, 0, 0);
    tbl[15] = mkv("r0_zero", 0, 0, 8'h00, Z, 0, 0, 0, 0, Z, Z, 0, 0);
    tbl[16] = mkv("w3_sb3", 1, 3, 8'hFF, mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30),
                  1, 3, 3, 9, mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 0, 0);
    tbl[17] = mkv("r3_pend", 0, 0, 8'h00, Z, 0, 0, 3, 9,
                  mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30),
                  mk8('h57,'h56,'h55,'h54,'h53,'h52,'h51,'h50), 1, 0);
    tbl[18] = mkv("sb3_again", 0, 0, 8'h00, Z, 1, 3, 3, 3,
                  mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30),
                  mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30), 1, 1);
    tbl[19] = mkv("r3_still_pend", 0, 0, 8'h00, Z, 0, 0, 3, 3,
                  mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30),
                  mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30), 1, 1);
    tbl[20] = mkv("w4_no_bypass3", 1, 4, 8'hFF, ONES, 0, 0, 3, 4,
                  mk8('h37,'h36,'h35,'h34,'h33,'h32,'h31,'h30), ONES, 1, 0);

    // reset and first sweep
    idle_inputs();
    rst_n = 1'b0;
    ra1 = 5'd5; ra2 = 5'd3;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_busy", 256'(clr_busy), 256'(1'b1));
    chk("reset_rd1", rd1, Z);
    chk("reset_pend1", 256'(rd1_pend), 256'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    sweep(0, n, bad);
    chk("init_busy_cycles", 256'(n), 256'(32));
    chk("init_busy_outputs", 256'(bad), 256'(0));

    errs = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); #2;
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      if (rd1 !== Z || rd2 !== Z || rd1_pend !== 1'b0 || rd2_pend !== 1'b0) errs++;
    end
    chk("init_all_zero", 256'(errs), 256'(0));

    // table-driven vectors
    for (int v = 0; v < NV; v++) begin
      @(negedge clk); #2;
      we = tbl[v].we; wa = tbl[v].wa; wmask = tbl[v].wmask; wd = tbl[v].wd;
      sb_set = tbl[v].sb_set; sb_addr = tbl[v].sb_addr;
      ra1 = tbl[v].ra1; ra2 = tbl[v].ra2;
      #1;
      chk({tbl[v].name, "_rd1"}, rd1, tbl[v].exp_rd1);
      chk({tbl[v].name, "_rd2"}, rd2, tbl[v].exp_rd2);
      chk({tbl[v].name, "_p1"}, 256'(rd1_pend), 256'(tbl[v].exp_p1));
      chk({tbl[v].name, "_p2"}, 256'(rd2_pend), 256'(tbl[v].exp_p2));
    end
    @(negedge clk); #2;
    idle_inputs();

    // clr_req from IDLE wipes data and pending bits
    @(negedge clk); #2;
    ra1 = 5'd3; ra2 = 5'd5;
    clr_req = 1'b1;
    #1;
    chk("clr_req_cycle_busy", 256'(clr_busy), 256'(1'b0));
    @(negedge clk); #2;
    clr_req = 1'b0;
    sweep(0, n, bad);
    chk("clr_busy_cycles", 256'(n), 256'(32));
    chk("clr_busy_outputs", 256'(bad), 256'(0));
    #1;
    chk("clr_r3_zero", rd1, Z);
    chk("clr_r3_pend", 256'(rd1_pend), 256'(1'b0));
    chk("clr_r5_zero", rd2, Z);
    @(negedge clk); #2;
    ra1 = 5'd7; ra2 = 5'd4;
    #1;
    chk("clr_r7_zero", rd1, Z);
    chk("clr_r4_zero", rd2, Z);

    // reset pulse in the middle of a sweep restarts it
    @(negedge clk); #2;
    we = 1'b1; wa = 5'd3; wd = ONES; wmask = 8'hFF;
    @(negedge clk); #2;
    we = 1'b0;
    ra1 = 5'd3; ra2 = 5'd5;
    #1;
    chk("pre_rst_r3", rd1, ONES);
    clr_req = 1'b1;
    @(negedge clk); #2;
    clr_req = 1'b0;
    sweep(10, n, bad);
    chk("rst_mid_busy_cycles", 256'(n), 256'(32));
    chk("rst_mid_outputs", 256'(bad), 256'(0));
    #1;
    chk("rst_mid_r3_zero", rd1, Z);
    chk("rst_mid_r5_zero", rd2, Z);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
